// File: rtl/vga_pixel_gen.sv
// Colour stage: fetches frame-memory pixels and emits sync-aligned VGA colour with a frame counter.
// Optional colour-bar test pattern is enabled by defining VGA_TESTPAT_EN.
module vga_pixel_gen #(
  parameter int unsigned DATA_W  = 3,
  parameter int unsigned V_MAX   = 95,
  parameter int unsigned FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         HPIXEL,
  input  logic [6:0]         VPIXEL,
  input  logic               H_RGB,
  input  logic               V_RGB,
  input  logic               HSYNC_IN,
  input  logic               VSYNC_IN,
`ifdef VGA_TESTPAT_EN
  input  logic               TEST_MODE,
`endif
  output logic [13:0]        MEM_ADDR,
  input  logic [DATA_W-1:0]  MEM_RDATA,
  output logic               VGA_RED,
  output logic               VGA_GREEN,
  output logic               VGA_BLUE,
  output logic               VGA_HSYNC,
  output logic               VGA_VSYNC,
  output logic [FRAME_W-1:0] FRAME_CNT,
  output logic               FRAME_DONE
);

  localparam int unsigned PIX_W = 7;
  localparam int unsigned BAR_W = 3;

  logic              de0, hs0, vs0;
  logic              de1, hs1, vs1;
  logic [DATA_W-1:0] colour_q;
  logic [DATA_W-1:0] pix_c;
  logic              vs_fall_c;

`ifdef VGA_TESTPAT_EN
  logic             tm0, tm1;
  logic [BAR_W-1:0] bar0, bar1;
`endif

  // Stage 0: issue read address and capture qualifiers alongside it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      MEM_ADDR <= '0;
      de0      <= 1'b0;
      hs0      <= 1'b1;
      vs0      <= 1'b1;
    end else begin
      MEM_ADDR <= {VPIXEL, HPIXEL};
      de0      <= H_RGB & V_RGB & (VPIXEL <= PIX_W'(V_MAX));
      hs0      <= HSYNC_IN;
      vs0      <= VSYNC_IN;
    end
  end

  // Stage 1: wait out the memory read latency
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      de1 <= 1'b0;
      hs1 <= 1'b1;
      vs1 <= 1'b1;
    end else begin
      de1 <= de0;
      hs1 <= hs0;
      vs1 <= vs0;
    end
  end

`ifdef VGA_TESTPAT_EN
  // Test-mode flag and bar index travel with the coordinate they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tm0  <= 1'b0;
      tm1  <= 1'b0;
      bar0 <= '0;
      bar1 <= '0;
    end else begin
      tm0  <= TEST_MODE;
      tm1  <= tm0;
      bar0 <= HPIXEL[6:4];
      bar1 <= bar0;
    end
  end

  always_comb begin
    pix_c = MEM_RDATA;
    if (tm1) pix_c = DATA_W'(bar1);
  end
`else
  always_comb begin
    pix_c = MEM_RDATA;
  end
`endif

  // Stage 2: blank or pass pixel, realign sync with colour
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      colour_q  <= '0;
      VGA_HSYNC <= 1'b1;
      VGA_VSYNC <= 1'b1;
    end else begin
      colour_q  <= de1 ? pix_c : '0;
      VGA_HSYNC <= hs1;
      VGA_VSYNC <= vs1;
    end
  end

  assign VGA_RED   = colour_q[2];
  assign VGA_GREEN = colour_q[1];
  assign VGA_BLUE  = colour_q[0];

  // vs0 already holds last cycle's VSYNC_IN, so it doubles as the edge detector
  assign vs_fall_c = vs0 & ~VSYNC_IN;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      FRAME_CNT  <= '0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= vs_fall_c;
      if (vs_fall_c) FRAME_CNT <= FRAME_CNT + FRAME_W'(1);
    end
  end

endmodule
